// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the write-port sequencer state type.
package rf_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_wb_state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus (valid/ready per requester) plus the registered register-file write port.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import rf_pkg::*;

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][XLEN-1:0]       req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               Reg_WRITE;
    logic [REG_ADDR_W-1:0]              WRITE_Addr;
    logic [XLEN-1:0]                    WRITE_Data;
    logic                               init_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, Reg_WRITE, WRITE_Addr, WRITE_Data, init_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, Reg_WRITE, WRITE_Addr, WRITE_Data, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping mod N.
// Zero latency; no state, so fairness depends on the caller advancing ptr past each grant.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);
    int   idx;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-fill sweep after reset, then round-robin writeback
// arbitration with a combinational ready and a 1-cycle registered write; x0 writes are swallowed.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [REG_ADDR_W-1:0] CLR_LAST = REG_ADDR_W'(NUM_REGS - 1);
    localparam rf_wb_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    rf_wb_state_t          state, state_nxt;
    logic [REG_ADDR_W-1:0] clr_cnt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  any_gnt;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  done;

    // Requests are invisible to the arbiter while the sweep owns the port.
    assign arb_req = (state == RUN) ? bus.req_valid : '0;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_gnt       = |gnt;
    assign bus.req_ready = gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == CLR_LAST) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= !CLEAR_ON_RESET;
            clr_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clr_cnt;
                    wr_data <= '0;
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (any_gnt) begin
                        // x0 is hardwired zero: accept the request but never drive the enable.
                        wr_en   <= (bus.req_addr[gnt_idx] != '0);
                        wr_addr <= bus.req_addr[gnt_idx];
                        wr_data <= bus.req_data[gnt_idx];
                        rr_ptr  <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                default: wr_en <= 1'b0;
            endcase
        end
    end

    assign bus.Reg_WRITE  = wr_en;
    assign bus.WRITE_Addr = wr_addr;
    assign bus.WRITE_Data = wr_data;
    assign bus.init_done  = done;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: sweep, arbitration order, x0 suppression, async reset.
module tb_regfile_write_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    regfile_write_arbiter_if #(.NUM_REQ(3)) bus ();

    regfile_write_arbiter #(
        .NUM_REQ        (3),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on a negedge just after reset release; leaves the bench on the negedge after x31.
    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("%s_we_%0d", name, i), 32'(bus.Reg_WRITE), 32'd1);
            check($sformatf("%s_addr_%0d", name, i), 32'(bus.WRITE_Addr), 32'(i));
            check($sformatf("%s_data_%0d", name, i), bus.WRITE_Data, 32'd0);
            check($sformatf("%s_done_%0d", name, i), 32'(bus.init_done), (i == 31) ? 32'd1 : 32'd0);
            if (i < 31) check($sformatf("%s_ready_%0d", name, i), 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = '0;
    endtask

    initial begin
        int order [6];
        int wait_c;
        int writes7;
        logic [31:0] data7;
        logic drop2;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        #1;
        check("rst_we",    32'(bus.Reg_WRITE),  32'd0);
        check("rst_addr",  32'(bus.WRITE_Addr), 32'd0);
        check("rst_data",  bus.WRITE_Data,      32'd0);
        check("rst_done",  32'(bus.init_done),  32'd0);
        check("rst_ready", 32'(bus.req_ready),  32'd0);

        // Requests held during the sweep must never see ready.
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 3'b111;
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        reset = 1'b0;
        sweep("sweep1");

        // Single write, then a lone request 2 so the pointer wraps back to 0.
        bus.req_valid = 3'b001;
        bus.req_addr[0] = 5'd5;
        bus.req_data[0] = 32'd10;
        #1 check("t2_ready", 32'(bus.req_ready), 32'b001);
        tick();
        bus.req_valid = '0;
        check("t2_we",   32'(bus.Reg_WRITE),  32'd1);
        check("t2_addr", 32'(bus.WRITE_Addr), 32'd5);
        check("t2_data", bus.WRITE_Data,      32'd10);

        bus.req_valid = 3'b100;
        bus.req_addr[2] = 5'd4;
        bus.req_data[2] = 32'd44;
        #1 check("wrap_ready", 32'(bus.req_ready), 32'b100);
        tick();
        bus.req_valid = '0;
        check("wrap_addr", 32'(bus.WRITE_Addr), 32'd4);
        check("wrap_data", bus.WRITE_Data,      32'd44);

        // Three continuous requesters: strict rotation 0,1,2,0,1,2.
        order = '{0, 1, 2, 0, 1, 2};
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_data  = {32'h102, 32'h101, 32'h100};
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("t3_ready_%0d", k), 32'(bus.req_ready), 32'(1 << order[k]));
            tick();
            check($sformatf("t3_we_%0d", k),   32'(bus.Reg_WRITE),  32'd1);
            check($sformatf("t3_addr_%0d", k), 32'(bus.WRITE_Addr), 32'(order[k] + 1));
            check($sformatf("t3_data_%0d", k), bus.WRITE_Data,      32'h100 + 32'(order[k]));
        end
        bus.req_valid = '0;

        // x0 write accepted but suppressed; pointer still moves past requester 1.
        bus.req_valid = 3'b010;
        bus.req_addr[1] = 5'd0;
        bus.req_data[1] = 32'hDEAD;
        #1 check("t4_ready", 32'(bus.req_ready), 32'b010);
        tick();
        check("t4_we",   32'(bus.Reg_WRITE),  32'd0);
        check("t4_addr", 32'(bus.WRITE_Addr), 32'd0);
        check("t4_data", bus.WRITE_Data,      32'hDEAD);
        bus.req_addr  = {5'd3, 5'd2, 5'd1};
        bus.req_valid = 3'b111;
        #1 check("t4_next_ready", 32'(bus.req_ready), 32'b100);
        tick();
        bus.req_valid = '0;
        check("t4_next_addr", 32'(bus.WRITE_Addr), 32'd3);
        tick();
        check("idle_we",   32'(bus.Reg_WRITE),  32'd0);
        check("idle_addr", 32'(bus.WRITE_Addr), 32'd3);

        // Requester 2 holds while 0 and 1 keep requesting; it must win exactly once, on the third cycle.
        bus.req_addr  = {5'd7, 5'd9, 5'd8};
        bus.req_data  = {32'h55, 32'h2, 32'h1};
        bus.req_valid = 3'b111;
        wait_c  = -1;
        writes7 = 0;
        data7   = '0;
        drop2   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.req_ready[2]) begin
                if (wait_c < 0) wait_c = c;
                drop2 = 1'b1;
            end
            tick();
            if (bus.Reg_WRITE && bus.WRITE_Addr == 5'd7) begin
                writes7++;
                data7 = bus.WRITE_Data;
            end
            if (drop2) bus.req_valid[2] = 1'b0;
        end
        bus.req_valid = '0;
        check("t6_wait",   32'(wait_c),  32'd2);
        check("t6_writes", 32'(writes7), 32'd1);
        check("t6_data",   data7,        32'h55);

        // Reset mid-sweep, between clock edges.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        check("t5_pre_addr", 32'(bus.WRITE_Addr), 32'd10);
        #2 reset = 1'b1;
        #1;
        check("t5_async_we",   32'(bus.Reg_WRITE),  32'd0);
        check("t5_async_addr", 32'(bus.WRITE_Addr), 32'd0);
        check("t5_async_data", bus.WRITE_Data,      32'd0);
        check("t5_async_done", 32'(bus.init_done),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        sweep("sweep2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
